// File: rtl/dense_classifier.sv
// Fully connected 3136->10 classifier over ReLU'd pool1 maps: streams weights from an
// external ROM, accumulates in 64 bits, scales/biases/saturates, then scans for the argmax.
module dense_classifier #(
   parameter int FRAC_BITS = 8,
   parameter int WEIGHT_W  = 16
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       start,
   output logic                       done,
   input  logic signed [31:0]         pooled_maps [0:15][0:13][0:13],
   input  logic signed [31:0]         bias [0:9],
   output logic [11:0]                weight_addr,
   output logic                       weight_rd_en,
   input  logic [10*WEIGHT_W-1:0]     weight_data,
   output logic signed [31:0]         logits [0:9],
   output logic [3:0]                 class_id
);

   // state  | meaning
   // IDLE   | waiting for start
   // MAC    | issuing weight reads for k = 0..3135, accumulating the previous index
   // DRAIN  | accumulating the final product (k = 3135)
   // FINAL  | shift, bias add and saturation into logits
   // ARGMAX | sequential scan of logits 0..9
   // DONE   | one-cycle done pulse, class_id valid
   typedef enum logic [2:0] {
      S_IDLE, S_MAC, S_DRAIN, S_FINAL, S_ARGMAX, S_DONE
   } state_t;

   localparam logic signed [64:0] SAT_MAX = 65'sd2147483647;
   localparam logic signed [64:0] SAT_MIN = -65'sd2147483648;

   state_t state, state_nxt;

   logic [11:0]                k;
   logic [3:0]                 f, i, j;
   logic [3:0]                 arg_c;
   logic                       mac_vld;
   logic signed [31:0]         x_d;
   logic signed [31:0]         pix;
   logic signed [31:0]         pix_relu;
   logic signed [63:0]         acc     [0:9];
   logic signed [WEIGHT_W-1:0] w       [0:9];
   logic signed [31+WEIGHT_W:0] prod   [0:9];
   logic signed [63:0]         acc_sh  [0:9];
   logic signed [64:0]         sum     [0:9];
   logic signed [31:0]         sat     [0:9];
   logic signed [31:0]         max_val, cand, best_val;
   logic [3:0]                 max_idx, best_idx;
   logic                       last_k;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   assign last_k = (k == 12'd3135);

   always_comb begin
      state_nxt = S_IDLE;
      case (state)
         S_IDLE:   state_nxt = start ? S_MAC : S_IDLE;
         S_MAC:    state_nxt = last_k ? S_DRAIN : S_MAC;
         S_DRAIN:  state_nxt = S_FINAL;
         S_FINAL:  state_nxt = S_ARGMAX;
         S_ARGMAX: state_nxt = (arg_c == 4'd9) ? S_DONE : S_ARGMAX;
         S_DONE:   state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   assign pix      = pooled_maps[f][i][j];
   assign pix_relu = pix[31] ? 32'sd0 : pix;

   // x_d lags the address by one cycle so it pairs with the ROM's registered output
   always_comb begin
      for (int c = 0; c < 10; c++) begin
         w[c]      = $signed(weight_data[c*WEIGHT_W +: WEIGHT_W]);
         prod[c]   = x_d * w[c];
         acc_sh[c] = acc[c] >>> FRAC_BITS;
         sum[c]    = {acc_sh[c][63], acc_sh[c]} + {{33{bias[c][31]}}, bias[c]};
         if (sum[c] > SAT_MAX)      sat[c] = 32'sh7FFF_FFFF;
         else if (sum[c] < SAT_MIN) sat[c] = 32'sh8000_0000;
         else                       sat[c] = sum[c][31:0];
      end
   end

   always_comb begin
      cand     = logits[arg_c];
      best_val = max_val;
      best_idx = max_idx;
      if (arg_c == 4'd0 || cand > max_val) begin
         best_val = cand;
         best_idx = arg_c;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         done         <= 1'b0;
         weight_rd_en <= 1'b0;
         weight_addr  <= '0;
         class_id     <= '0;
         k            <= '0;
         f            <= '0;
         i            <= '0;
         j            <= '0;
         x_d          <= '0;
         mac_vld      <= 1'b0;
         arg_c        <= '0;
         max_val      <= '0;
         max_idx      <= '0;
         for (int c = 0; c < 10; c++) begin
            acc[c]    <= '0;
            logits[c] <= '0;
         end
      end else begin
         done         <= (state_nxt == S_DONE);
         weight_rd_en <= (state_nxt == S_MAC);
         mac_vld      <= (state == S_MAC);
         x_d          <= pix_relu;
         if (mac_vld) begin
            for (int c = 0; c < 10; c++)
               acc[c] <= acc[c] + {{(32-WEIGHT_W){prod[c][31+WEIGHT_W]}}, prod[c]};
         end
         case (state)
            S_IDLE: begin
               if (start) begin
                  for (int c = 0; c < 10; c++) acc[c] <= '0;
                  k           <= '0;
                  f           <= '0;
                  i           <= '0;
                  j           <= '0;
                  weight_addr <= '0;
               end
            end
            S_MAC: begin
               if (!last_k) begin
                  k           <= k + 12'd1;
                  weight_addr <= k + 12'd1;
                  if (j == 4'd13) begin
                     j <= '0;
                     if (i == 4'd13) begin
                        i <= '0;
                        f <= f + 4'd1;
                     end else begin
                        i <= i + 4'd1;
                     end
                  end else begin
                     j <= j + 4'd1;
                  end
               end
            end
            S_FINAL: begin
               for (int c = 0; c < 10; c++) logits[c] <= sat[c];
               arg_c <= '0;
            end
            S_ARGMAX: begin
               max_val <= best_val;
               max_idx <= best_idx;
               arg_c   <= arg_c + 4'd1;
               if (arg_c == 4'd9) class_id <= best_idx;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dense_classifier.sv
// Randomized bench for dense_classifier: a synchronous weight ROM model plus a plain
// arithmetic reference for logits and argmax, with latency, reset and start-glitch cases.
module tb_dense_classifier;
   localparam int WW = 16;
   localparam int FB = 8;

   logic                  clk = 1'b0;
   logic                  reset_n = 1'b0;
   logic                  start = 1'b0;
   logic                  done;
   logic signed [31:0]    pm [0:15][0:13][0:13];
   logic signed [31:0]    bias [0:9];
   logic [11:0]           weight_addr;
   logic                  weight_rd_en;
   logic [10*WW-1:0]      weight_data = '0;
   logic signed [31:0]    logits [0:9];
   logic [3:0]            class_id;

   logic signed [WW-1:0]  rom [0:3135][0:9];
   longint                exp_log [0:9];
   int                    exp_cls;
   int                    n_chk = 0;
   int                    n_fail = 0;
   int                    done_cnt = 0;

   dense_classifier #(.FRAC_BITS(FB), .WEIGHT_W(WW)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .done(done),
      .pooled_maps(pm), .bias(bias), .weight_addr(weight_addr),
      .weight_rd_en(weight_rd_en), .weight_data(weight_data),
      .logits(logits), .class_id(class_id)
   );

   always #5 clk = ~clk;

   // one-cycle read latency ROM
   always @(posedge clk) begin
      if (weight_rd_en)
         for (int c = 0; c < 10; c++) weight_data[c*WW +: WW] <= rom[weight_addr][c];
   end

   always @(negedge clk) if (done === 1'b1) done_cnt++;

   task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic fill(input int mode);
      for (int f = 0; f < 16; f++)
         for (int i = 0; i < 14; i++)
            for (int j = 0; j < 14; j++)
               case (mode)
                  0: pm[f][i][j] = 1;
                  1: pm[f][i][j] = -5;
                  2, 5: pm[f][i][j] = 32'sh7FFF_FFFF;
                  3: pm[f][i][j] = 3;
                  default: pm[f][i][j] = int'($urandom_range(0, 2097152)) - 1048576;
               endcase
      for (int k = 0; k < 3136; k++)
         for (int c = 0; c < 10; c++)
            case (mode)
               0: rom[k][c] = (c == 3) ? 16'sd256 : 16'sd0;
               2: rom[k][c] = 16'sd32767;
               3: rom[k][c] = (k == 3135 && c == 7) ? 16'sd512 : 16'sd0;
               5: rom[k][c] = -16'sd32768;
               default: rom[k][c] = 16'($urandom);
            endcase
      for (int c = 0; c < 10; c++)
         case (mode)
            0, 2, 3: bias[c] = 0;
            1: bias[c] = c - 4;
            default: bias[c] = int'($urandom_range(0, 2000000)) - 1000000;
         endcase
   endtask

   task automatic model();
      longint acc [0:9];
      longint x, v;
      int k;
      for (int c = 0; c < 10; c++) acc[c] = 0;
      for (int f = 0; f < 16; f++)
         for (int i = 0; i < 14; i++)
            for (int j = 0; j < 14; j++) begin
               x = pm[f][i][j];
               if (x < 0) x = 0;
               k = f*196 + i*14 + j;
               for (int c = 0; c < 10; c++) acc[c] += x * longint'(rom[k][c]);
            end
      for (int c = 0; c < 10; c++) begin
         v = (acc[c] >>> FB) + longint'(bias[c]);
         if (v > 64'sd2147483647) v = 64'sd2147483647;
         if (v < -64'sd2147483648) v = -64'sd2147483648;
         exp_log[c] = v;
      end
      exp_cls = 0;
      for (int c = 1; c < 10; c++) if (exp_log[c] > exp_log[exp_cls]) exp_cls = c;
   endtask

   task automatic run_case(input string name, input bit glitch);
      int cnt;
      int d0;
      model();
      d0 = done_cnt;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      cnt = 1;
      while (done !== 1'b1 && cnt < 4000) begin
         start = (glitch && (cnt == 500 || cnt == 3143)) ? 1'b1 : 1'b0;
         @(negedge clk);
         cnt++;
      end
      start = 1'b0;
      check({name, " latency"}, cnt, 3149);
      for (int c = 0; c < 10; c++) check($sformatf("%s logit%0d", name, c), logits[c], exp_log[c]);
      check({name, " class_id"}, class_id, exp_cls);
      @(negedge clk);
      check({name, " done width"}, done, 0);
      check({name, " rd_en idle"}, weight_rd_en, 0);
      repeat (5) @(negedge clk);
      check({name, " done pulses"}, done_cnt - d0, 1);
      check({name, " logit hold"}, logits[exp_cls], exp_log[exp_cls]);
   endtask

   initial begin
      int cnt;
      int d0;
      fill(0);
      repeat (3) @(negedge clk);
      check("rst done", done, 0);
      check("rst rd_en", weight_rd_en, 0);
      check("rst addr", weight_addr, 0);
      check("rst class", class_id, 0);
      check("rst logit0", logits[0], 0);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      run_case("ones_c3", 0);
      check("ones_c3 logit3 const", logits[3], 3136);
      check("ones_c3 class const", class_id, 3);
      fill(1); run_case("neg_relu", 1);
      fill(2); run_case("pos_sat", 0);
      fill(3); run_case("last_align", 0);
      check("last_align logit7 const", logits[7], 6);
      fill(5); run_case("neg_sat", 0);
      fill(4); run_case("rand_a", 1);

      fill(4); model();
      d0 = done_cnt;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      cnt = 1;
      while (cnt < 1000) begin @(negedge clk); cnt++; end
      check("mid rd_en", weight_rd_en, 1);
      check("mid addr", weight_addr, 999);
      reset_n = 1'b0;
      #1;
      check("abort rd_en", weight_rd_en, 0);
      check("abort addr", weight_addr, 0);
      check("abort class", class_id, 0);
      check("abort logit", logits[4], 0);
      @(negedge clk) reset_n = 1'b1;
      repeat (3200) @(negedge clk);
      check("abort no done", done_cnt - d0, 0);
      run_case("post_reset", 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/dense_classifier.md
DENSE_CLASSIFIER -- requirements
Module: dense_classifier

Interface
REQ-001 Parameter FRAC_BITS, default 8: fractional bits of weights; arithmetic right shift applied to each accumulator before bias add.
REQ-002 Parameter WEIGHT_W, default 16: signed width of each weight.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  begin one classification; sampled only in IDLE.
REQ-006 done  output  1  registered; high exactly one cycle when results are valid.
REQ-007 pooled_maps  input  signed 32 x [0:15][0:13][0:13]  pool1 output; held stable by the source from start until done.
REQ-008 bias  input  signed 32 x [0:9]  per-class bias, integer units; stable start..done.
REQ-009 weight_addr  output  12  flattened input index, 0..3135.
REQ-010 weight_rd_en  output  1  weight ROM read strobe.
REQ-011 weight_data  input  10*WEIGHT_W  signed weights for index (weight_addr of previous cycle); class c at bits [c*WEIGHT_W +: WEIGHT_W].
REQ-012 logits  output  signed 32 x [0:9]  registered class scores.
REQ-013 class_id  output  4  registered argmax of logits.

Function
REQ-014 States: IDLE, MAC, DRAIN, FINAL, ARGMAX, DONE; any undefined encoding returns to IDLE.
REQ-015 IDLE -> MAC when start=1 (cycle T); start ignored in every other state.
REQ-016 On entering MAC: all ten 64-bit signed accumulators cleared to 0, index k cleared to 0.
REQ-017 MAC lasts exactly 3136 cycles (T+1..T+3136); cycle T+1+k drives weight_addr=k, weight_rd_en=1.
REQ-018 Flatten order: k = f*196 + i*14 + j, f outer, j inner.
REQ-019 ROM read latency is one cycle: weight_data in cycle T+2+k belongs to index k; block holds x_k one cycle to align.
REQ-020 ReLU on input: x_k = pooled_maps[f][i][j] if non-negative, else 0.
REQ-021 Accumulate: acc[c] += x_k * w[c], full-precision signed product (32+WEIGHT_W bits), sign-extended to 64; no overflow possible.
REQ-022 DRAIN (T+3137): weight_rd_en=0, last product (k=3135) accumulated.
REQ-023 FINAL (T+3138): logits[c] = saturate32((acc[c] >>> FRAC_BITS) + bias[c]); clamp to [-2^31, 2^31-1].
REQ-024 ARGMAX: 10 cycles (T+3139..T+3148), scans c=0..9 sequentially; replaces running max only on strictly greater; ties resolve to lowest index.
REQ-025 DONE (T+3149): done=1, class_id valid; next cycle IDLE, done=0.
REQ-026 Start-to-done latency is exactly 3149 cycles.
REQ-027 logits and class_id hold their values from DONE until FINAL/ARGMAX of the next run overwrites them.
REQ-028 weight_addr holds last driven value outside MAC; weight_rd_en=0 outside MAC.
REQ-029 start held high continuously: one run per IDLE visit; new run begins the cycle after returning to IDLE.

Reset
REQ-030 reset_n=0 asynchronously forces: state IDLE, done=0, weight_rd_en=0, weight_addr=0, class_id=0, all logits=0, accumulators=0, k=0.
REQ-031 Reset asserted mid-run aborts the run; no done pulse; first start after release begins a full fresh run.

Verification
REQ-032 All inputs 1, class3 weights 256, others 0, bias 0 -> logits[3]=3136, others 0, class_id=3, done at T+3149.
REQ-033 All inputs -5, weights arbitrary, bias[c]=c-4 -> logits = -4..5, class_id=9 (ReLU zeroes inputs).
REQ-034 Inputs 2^31-1, all weights 2^15-1, bias 0 -> every logit 2147483647 (saturated), class_id=0 (tie).
REQ-035 Weights with ROM latency model: single nonzero at k=3135, class7 = 512, input 3 -> logits[7]=6; checks alignment of last element.
REQ-036 reset_n pulsed low at T+1000 -> outputs zero, no done; subsequent start yields correct full result in 3149 cycles.
REQ-037 start pulsed during MAC and ARGMAX -> ignored; exactly one done pulse per accepted start.
